// File: rtl/ooo_pkg.sv
// Shared out-of-order core constants and types for the rename-stage physical register file.
package ooo_pkg;

    localparam int NUM_PREGS = 128;
    localparam int NUM_AREGS = 32;
    localparam int PREG_W    = $clog2(NUM_PREGS);
    localparam int CNT_W     = $clog2(NUM_PREGS + 1);

    typedef logic [PREG_W-1:0] preg_t;

    function automatic logic [NUM_PREGS-1:0] preg_onehot(input preg_t p);
        return {{(NUM_PREGS-1){1'b0}}, 1'b1} << p;
    endfunction

endpackage

// File: rtl/preg_free_list_ff_pick.sv
// Find-first picker: lowest index set in bitmap and not masked, plus a found flag.
module ff_pick
    import ooo_pkg::*;
#(
    parameter int N = NUM_PREGS,
    parameter int W = PREG_W
) (
    input  logic [N-1:0] bitmap,
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         vld
);

    // Priority scan, lowest index wins; idx stays 0 when nothing is available
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bitmap[i] && !mask[i] && !vld) begin
                idx = W'(i);
                vld = 1'b1;
            end else begin
                vld = vld;
            end
        end
    end

endmodule

// File: rtl/preg_free_list.sv
// Physical register free list: bitmap of free pregs, multi-lane all-or-nothing alloc, checked multi-lane free.
module preg_free_list
    import ooo_pkg::*;
#(
    parameter int ALLOC_W = 2,
    parameter int FREE_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ALLOC_W-1:0]        alloc_req,
    output logic                      alloc_gnt,
    output logic [ALLOC_W*PREG_W-1:0] alloc_preg,
    input  logic [FREE_W-1:0]         free_vld,
    input  logic [FREE_W*PREG_W-1:0]  free_preg,
    output logic [CNT_W-1:0]          free_count,
    output logic                      empty,
    output logic                      err_double_free
);

    localparam int NW = $clog2(ALLOC_W + 1);
    localparam int FW = $clog2(FREE_W + 1);
    localparam logic [NUM_PREGS-1:0] RST_MAP = {{(NUM_PREGS-NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
    localparam logic [CNT_W-1:0]     RST_CNT = CNT_W'(NUM_PREGS - NUM_AREGS);

    logic [NUM_PREGS-1:0] bitmap_q, bitmap_d;
    logic [CNT_W-1:0]     free_count_q, free_count_d;
    logic                 empty_q, empty_d;
    logic                 err_q, err_d;

    logic [NUM_PREGS-1:0] mask_s [ALLOC_W+1];
    preg_t                pick_idx_s [ALLOC_W];
    logic [ALLOC_W-1:0]   pick_vld_s;
    logic [NW-1:0]        n_s;
    logic                 gnt_s;
    logic [NUM_PREGS-1:0] grant_bits_s;
    logic [NUM_PREGS-1:0] set_bits_s;
    logic [FW-1:0]        acc_s;
    logic                 drop_err_s;

    // Each lane excludes the pregs already picked by lower lanes
    assign mask_s[0] = '0;
    for (genvar g = 0; g < ALLOC_W; g++) begin : g_lane
        ff_pick u_pick (
            .bitmap (bitmap_q),
            .mask   (mask_s[g]),
            .idx    (pick_idx_s[g]),
            .vld    (pick_vld_s[g])
        );
        assign mask_s[g+1] = mask_s[g] | (pick_vld_s[g] ? preg_onehot(pick_idx_s[g]) : '0);
        assign alloc_preg[g*PREG_W +: PREG_W] = pick_idx_s[g];
    end

    // Grant decision: all requested lanes or none
    always_comb begin
        n_s          = '0;
        grant_bits_s = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            n_s = n_s + NW'(alloc_req[i]);
        end
        gnt_s = (n_s != '0) && (free_count_q >= CNT_W'(n_s));
        for (int i = 0; i < ALLOC_W; i++) begin
            if (gnt_s && alloc_req[i]) begin
                grant_bits_s = grant_bits_s | preg_onehot(pick_idx_s[i]);
            end else begin
                grant_bits_s = grant_bits_s;
            end
        end
    end

    // Free-lane legality; a preg granted this cycle is still free in bitmap_q, so it reads as a double free
    always_comb begin
        preg_t p;
        logic  dup;
        p          = '0;
        dup        = 1'b0;
        set_bits_s = '0;
        acc_s      = '0;
        drop_err_s = 1'b0;
        for (int j = 0; j < FREE_W; j++) begin
            p   = free_preg[j*PREG_W +: PREG_W];
            dup = 1'b0;
            for (int k = 0; k < j; k++) begin
                if (free_vld[k] && (free_preg[k*PREG_W +: PREG_W] == p)) begin
                    dup = 1'b1;
                end else begin
                    dup = dup;
                end
            end
            if (!free_vld[j] || (p == '0)) begin
                acc_s = acc_s;
            end else if (({1'b0, p} >= (PREG_W+1)'(NUM_PREGS)) || dup || bitmap_q[p]) begin
                drop_err_s = 1'b1;
            end else begin
                set_bits_s = set_bits_s | preg_onehot(p);
                acc_s      = acc_s + FW'(1);
            end
        end
    end

    // Next-state image
    always_comb begin
        bitmap_d     = (bitmap_q & ~grant_bits_s) | set_bits_s;
        free_count_d = free_count_q - (gnt_s ? CNT_W'(n_s) : '0) + CNT_W'(acc_s);
        empty_d      = (free_count_d == '0);
        err_d        = drop_err_s;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap_q     <= RST_MAP;
            free_count_q <= RST_CNT;
            empty_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            bitmap_q     <= bitmap_d;
            free_count_q <= free_count_d;
            empty_q      <= empty_d;
            err_q        <= err_d;
        end
    end

    assign alloc_gnt       = gnt_s;
    assign free_count      = free_count_q;
    assign empty           = empty_q;
    assign err_double_free = err_q;

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: reset image, alloc/drain, free legality, async reset.
module tb_preg_free_list;
    import ooo_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           alloc_req;
    logic                 alloc_gnt;
    logic [2*PREG_W-1:0]  alloc_preg;
    logic [1:0]           free_vld;
    logic [2*PREG_W-1:0]  free_preg;
    logic [CNT_W-1:0]     free_count;
    logic                 empty;
    logic                 err_double_free;

    int checks = 0;
    int errors = 0;

    preg_free_list #(.ALLOC_W(2), .FREE_W(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_req       (alloc_req),
        .alloc_gnt       (alloc_gnt),
        .alloc_preg      (alloc_preg),
        .free_vld        (free_vld),
        .free_preg       (free_preg),
        .free_count      (free_count),
        .empty           (empty),
        .err_double_free (err_double_free)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counter must always match the bitmap population
    always @(negedge clk) begin
        if (rst_n) begin
            assert ($countones(dut.bitmap_q) == int'(dut.free_count_q))
                else $error("FAIL invariant count=%0d pop=%0d", dut.free_count_q, $countones(dut.bitmap_q));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_free(input logic [1:0] v, input int p0, input int p1);
        free_vld                     = v;
        free_preg[PREG_W-1:0]        = PREG_W'(p0);
        free_preg[2*PREG_W-1:PREG_W] = PREG_W'(p1);
    endtask

    function automatic logic [31:0] lane(input int i);
        return 32'(alloc_preg[i*PREG_W +: PREG_W]);
    endfunction

    initial begin
        rst_n     = 1'b0;
        alloc_req = 2'b00;
        set_free(2'b00, 0, 0);
        #12 rst_n = 1'b1;
        #1;

        // 1: reset image
        check("rst_count", 32'(free_count), 32'd96);
        check("rst_empty", 32'(empty), 32'd0);
        check("rst_err",   32'(err_double_free), 32'd0);
        check("rst_lane0", lane(0), 32'd32);
        check("rst_lane1", lane(1), 32'd33);
        check("rst_gnt",   32'(alloc_gnt), 32'd0);

        // 2: dual allocation
        alloc_req = 2'b11;
        #1;
        check("a2_gnt", 32'(alloc_gnt), 32'd1);
        tick();
        alloc_req = 2'b00;
        check("a2_count", 32'(free_count), 32'd94);
        check("a2_lane0", lane(0), 32'd34);
        check("a2_lane1", lane(1), 32'd35);

        // 3: drain to one free preg (127), then exhaust it
        alloc_req = 2'b11;
        for (int i = 0; i < 46; i++) tick();
        alloc_req = 2'b01;
        tick();
        alloc_req = 2'b00;
        check("d3_count1", 32'(free_count), 32'd1);
        check("d3_lane0",  lane(0), 32'd127);
        check("d3_lane1",  lane(1), 32'd0);
        alloc_req = 2'b11;
        #1;
        check("d3_nogrant", 32'(alloc_gnt), 32'd0);
        tick();
        check("d3_count_hold", 32'(free_count), 32'd1);
        alloc_req = 2'b01;
        #1;
        check("d3_gnt1", 32'(alloc_gnt), 32'd1);
        tick();
        alloc_req = 2'b00;
        check("d3_count0", 32'(free_count), 32'd0);
        check("d3_empty",  32'(empty), 32'd1);

        // 4: free and alloc together from empty
        set_free(2'b01, 40, 0);
        alloc_req = 2'b01;
        #1;
        check("e4_gnt", 32'(alloc_gnt), 32'd0);
        tick();
        alloc_req = 2'b00;
        set_free(2'b00, 0, 0);
        check("e4_count", 32'(free_count), 32'd1);
        check("e4_lane0", lane(0), 32'd40);
        check("e4_empty", 32'(empty), 32'd0);

        // 5: illegal frees
        set_free(2'b01, 50, 0);
        tick();
        check("f5_free50", 32'(free_count), 32'd2);
        check("f5_err0",   32'(err_double_free), 32'd0);
        set_free(2'b01, 50, 0);
        tick();
        check("f5_dbl_err",   32'(err_double_free), 32'd1);
        check("f5_dbl_count", 32'(free_count), 32'd2);
        set_free(2'b11, 60, 60);
        tick();
        check("f5_dup_err",   32'(err_double_free), 32'd1);
        check("f5_dup_count", 32'(free_count), 32'd3);
        set_free(2'b00, 0, 0);
        tick();
        check("f5_err_pulse", 32'(err_double_free), 32'd0);
        set_free(2'b01, 0, 0);
        tick();
        set_free(2'b00, 0, 0);
        check("f5_x0_count", 32'(free_count), 32'd3);
        check("f5_x0_err",   32'(err_double_free), 32'd0);
        alloc_req = 2'b01;
        set_free(2'b01, 40, 0);
        #1;
        check("f5_race_gnt", 32'(alloc_gnt), 32'd1);
        tick();
        alloc_req = 2'b00;
        set_free(2'b00, 0, 0);
        check("f5_race_err",   32'(err_double_free), 32'd1);
        check("f5_race_count", 32'(free_count), 32'd2);
        check("f5_race_lane0", lane(0), 32'd50);
        check("f5_race_lane1", lane(1), 32'd60);

        // 6: asynchronous reset mid-burst
        alloc_req = 2'b11;
        set_free(2'b11, 32, 33);
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("r6_count", 32'(free_count), 32'd96);
        check("r6_lane0", lane(0), 32'd32);
        check("r6_lane1", lane(1), 32'd33);
        check("r6_empty", 32'(empty), 32'd0);
        check("r6_err",   32'(err_double_free), 32'd0);
        alloc_req = 2'b00;
        set_free(2'b00, 0, 0);
        #3 rst_n = 1'b1;
        tick();
        check("r6_post_count", 32'(free_count), 32'd96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
